i2c_target: RTL
===============

Name: i2c_target

Overview:
- I2C target (slave) responder, 7-bit addressing; the receiving end of the codec-style register-write protocol the board drives at bring-up.
- Used in two places: as a bench model standing in for the codec behind the init master, and as a host-configurable register port for eurorack-pmod gateware.
- Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its address, and exposes register writes and reads as single-cycle strobes.
- Never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h10, 7-bit target address matched against the first byte after START.
- REG_W, 8, register-pointer width; pointer wraps modulo 2^REG_W.

Ports:
- clk  in  1  system clock; must run at least 8x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL pin value.
- sda_i  in  1  raw SDA pin value.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  out  REG_W  current register pointer.
- wr_data  out  8  received data byte; valid while wr_stb=1.
- wr_stb  out  1  one-cycle pulse, write reg_addr <= wr_data.
- rd_stb  out  1  one-cycle pulse requesting rd_data for reg_addr.
- rd_data  in  8  read data; sampled one SCL falling edge after rd_stb.
- busy  out  1  1 between an addressed START and the next STOP.

Behaviour:
- Reset:
  - Clock/reset: already decided — one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - All outputs 0 and state IDLE; synchronizer flops reset to 1 (bus idle).
- Input path:
  - 2-flop synchronizer per line; edges detected on synchronized values.
  - Input-to-edge latency is 2 clk.
- Bus events:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are legal in any state, including mid-byte.
  - START resets the bit counter and enters ADDR; a repeated START does not clear reg_addr.
  - STOP releases sda_oe the next clk and enters IDLE; busy=0.
- Bit timing:
  - SDA sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the clk after an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - After 8 bits, compare bits[7:1] with DEV_ADDR.
  - Mismatch -> IGNORE (sda_oe stays 0 until START/STOP).
  - Match -> ADDR_ACK: sda_oe=1 from the 8th falling edge to the 9th falling edge; busy=1.
  - After ACK: R/W=0 -> REG; R/W=1 -> RDATA.
- REG:
  - 8 bits received; reg_addr <= byte[REG_W-1:0] on the 8th rising edge.
  - ACK as above, then -> WDATA.
- WDATA:
  - After the 8th bit, wr_data=byte and wr_stb pulses for 1 clk coincident with the ACK drive.
  - reg_addr increments at the 9th falling edge; loop to WDATA.
- RDATA:
  - rd_stb pulses 1 clk when entering ADDR_ACK (read) or at the 9th rising edge of RDATA_ACK.
  - Shift register loads rd_data at the next SCL falling edge.
  - sda_oe = ~bit for 8 bits, then released for RDATA_ACK.
- RDATA_ACK:
  - Sample SDA on the 9th rising edge; reg_addr increments.
  - Master ACK (0) -> RDATA.
  - Master NACK (1) -> IGNORE.
- Boundaries:
  - reg_addr wraps 2^REG_W-1 -> 0.
  - START and STOP never coincide; STOP wins if both are flagged in the same clk.
  - START during an ACK bit releases sda_oe immediately.
  - Reset mid-transaction releases SDA asynchronously.

Optional Feature:
- I2C_TARGET_GLITCH_FILTER_EN defined:
  - A 3-sample majority filter follows the synchronizer on each line.
  - Pulses shorter than 2 clk are rejected.
  - Input latency becomes 4 clk.
- Undefined: no filter; latency 2 clk.

Decomposition:
- Package i2c_pkg:
  - state enum;
  - I2C_ACK=1'b0, I2C_NACK=1'b1;
  - bit-count width constant (4 bits, values 0..8).
- Sub-module i2c_line_sync:
  - synchronizer, optional majority filter, and rise/fall edge flags for one line;
  - instantiated twice (SCL, SDA).

Test Plan:
- Write burst: START, 0x20 (DEV_ADDR 0x10, W), 0x12, 0x34, 0x56, STOP.
  - Expect ACK on all four bytes.
  - wr_stb twice: (reg_addr 0x12, 0x34) then (0x13, 0x56).
  - Final reg_addr 0x14; busy 0 after STOP.
- Address mismatch: START, 0x22, 0x12, STOP.
  - Expect sda_oe never 1, no strobes, busy stays 0.
- Combined read: write pointer 0x7F, repeated START, 0x21, two bytes (rd_data returns 0xA5 then 0x3C), master ACK then NACK.
  - Expect SDA bits 0xA5, 0x3C.
  - Two rd_stb pulses at reg_addr 0x7F, 0x80.
  - IGNORE after NACK.
- Wrap: REG_W=8, pointer 0xFF, write two bytes.
  - Expect wr_stb at 0xFF then 0x00.
- Abort: STOP after 4 bits of a data byte.
  - Expect no wr_stb, sda_oe 0, IDLE.
  - Separately, assert rst_n low during an ACK bit: expect sda_oe 0 asynchronously.
- Glitch (with I2C_TARGET_GLITCH_FILTER_EN): 1-clk low pulse on SDA while SCL high.
  - Expect no START detected.
  - Without the macro, expect a START detected.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target.
// Latency: n/a (declarations only).
// Flow control: n/a.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter holds 0..8 (8 = byte complete, ACK slot next).
  localparam int                   BIT_CNT_W     = 4;
  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT      = 4'd7;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes one open-drain bus line and flags its rising/falling edges.
// Latency: pin to level/edge flag 2 clk; 4 clk when I2C_TARGET_GLITCH_FILTER_EN is defined.
// Flow control: none; flags are single-cycle and must be consumed when raised.
// Ports: clk, rst_n (async, active-low); line = raw pin; level = cleaned value;
//        rise/fall = one-cycle edge flags on level.
// Build option: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  // Reset to 1: an idle I2C line is pulled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], line};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 3'b111;
    else        hist <= {hist[1:0], sync[1]};
  end

  // A single-clk pulse only ever occupies one history slot, so it never wins the vote.
  assign level = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign level = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-addressed I2C target turning bus writes/reads into one-cycle register strobes.
// Latency: bus edge to internal event 2 clk (4 with filter); sda_oe/strobes registered 1 clk later.
// Flow control: none on the host side and no clock stretching; rd_data must be valid by the next SCL fall after rd_stb.
// Ports: clk, rst_n (async, active-low); scl_i/sda_i = raw pins; sda_oe = pull SDA low;
//        reg_addr = register pointer; wr_data/wr_stb = write strobe; rd_stb/rd_data = read request/data;
//        busy = addressed transaction in progress.
// Build option: I2C_TARGET_GLITCH_FILTER_EN enables majority filtering in i2c_line_sync.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h10,
  parameter int         REG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [REG_W-1:0] reg_addr,
  output logic [7:0]       wr_data,
  output logic             wr_stb,
  output logic             rd_stb,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic                 rw;
  logic                 master_ack;
  logic [7:0]           rx_byte;
  logic                 byte_done;

  assign rx_byte   = {shreg[6:0], sda};
  assign byte_done = (bit_cnt == BITS_PER_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      master_ack <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr   <= '0;
      wr_data    <= '0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      // STOP outranks START if both ever flag together.
      if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        // Repeated START keeps reg_addr so a pointer write can precede a read.
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (scl_fall && byte_done) begin
              bit_cnt <= '0;
              if (shreg[7:1] == DEV_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
                rd_stb <= shreg[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          REG: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              if (bit_cnt == LAST_BIT) reg_addr <= REG_W'(rx_byte);
            end else if (scl_fall && byte_done) begin
              state  <= REG_ACK;
              sda_oe <= 1'b1;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (scl_fall && byte_done) begin
              state   <= WDATA_ACK;
              sda_oe  <= 1'b1;
              wr_data <= shreg;
              wr_stb  <= 1'b1;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                // First read bit goes out on the same falling edge that ends the ACK.
                shreg  <= rd_data;
                sda_oe <= ~rd_data[7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= REG;
              end
            end
          end
          REG_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              state   <= WDATA;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt  <= '0;
              sda_oe   <= 1'b0;
              reg_addr <= reg_addr + REG_W'(1);
              state    <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (scl_fall) begin
              if (byte_done) begin
                sda_oe <= 1'b0;
                state  <= RDATA_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              reg_addr   <= reg_addr + REG_W'(1);
              master_ack <= (sda == I2C_ACK);
              rd_stb     <= (sda == I2C_ACK);
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (master_ack) begin
                shreg  <= rd_data;
                sda_oe <= ~rd_data[7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end
          default: ;  // IDLE and IGNORE wait for START/STOP
        endcase
      end
    end
  end

endmodule
